// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher and its queue.
package inst_fetcher_pkg;

  // Fetch FSM: IDLE may issue, WAIT owns a live request, DISCARD drains a
  // request whose data was invalidated by a redirect.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // One queue entry: the fetch address and the word that came back from it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/inst_fetcher_if.sv
// Memory-controller handshake plus dispatcher-facing instruction stream.
interface inst_fetcher_if;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;
  logic        ID_stall;
  logic        inst_flag;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  // Fetcher side.
  modport master (
    output mc_req, mc_addr, inst_flag, inst, inst_pc,
    input  mc_done, mc_data, ID_stall
  );

  // Memory controller / dispatcher side.
  modport slave (
    input  mc_req, mc_addr, inst_flag, inst, inst_pc,
    output mc_done, mc_data, ID_stall
  );
endinterface

// File: rtl/inst_fetcher_queue.sv
// Small synchronous FIFO of {pc,inst} entries. Head is read combinationally;
// while empty the head holds the last value it showed.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int IQ_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  iq_entry_t wdata,
  output iq_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int            PW      = $clog2(IQ_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(IQ_DEPTH);
  localparam logic [PW:0]   CONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PONE    = PW'(1);

  iq_entry_t       mem [IQ_DEPTH];
  iq_entry_t       hold_q;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;
  logic            push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? hold_q : mem[rd_ptr];

  // Pointers, occupancy and last-head hold; flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else if (en) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        hold_q <= head;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PONE;
        if (pop_ok)  rd_ptr <= rd_ptr + PONE;
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CONE;
          2'b01:   count <= count - CONE;
          default: count <= count;
        endcase
        if (!empty) hold_q <= mem[rd_ptr];
      end
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (en && !flush && push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetcher.sv
// Sequential-PC instruction fetcher: one outstanding memory request at a
// time, a small queue toward the dispatcher, redirects from commit.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy,
  input  logic           jump_flag,
  input  logic [31:0]    jump_pc,
  inst_fetcher_if.master bus
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic         push, pop, flush;
  logic         full, empty;
  iq_entry_t    head, wdata;

  assign bus.mc_req    = req_q;
  assign bus.mc_addr   = addr_q;
  assign bus.inst_flag = !empty;
  assign bus.inst      = head.inst;
  assign bus.inst_pc   = head.pc;

  assign pop        = !empty && !bus.ID_stall && !jump_flag;
  assign wdata.pc   = addr_q;
  assign wdata.inst = bus.mc_data;

  // Next-state: request issue, response capture, redirect/flush handling.
  // Room check uses !full: in IDLE nothing is in flight, so that is the
  // whole budget, and only one request may be outstanding.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (jump_flag) begin
          pc_d  = jump_pc;
          flush = 1'b1;
        end else if (!full) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (jump_flag) begin
          pc_d  = jump_pc;
          flush = 1'b1;
          if (bus.mc_done) begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
          end
        end else if (bus.mc_done) begin
          push    = 1'b1;
          pc_d    = pc_q + PC_STEP;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (jump_flag) begin
          pc_d  = jump_pc;
          flush = 1'b1;
        end
        if (bus.mc_done) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PC and registered memory request; everything holds while !rdy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  inst_queue #(.IQ_DEPTH(IQ_DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rdy),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a latency-programmable memory model
// and a scoreboard of words the dispatcher should see, in order.
module tb_inst_fetcher;
  import inst_fetcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_pc = 32'h0;

  inst_fetcher_if bus();

  inst_fetcher #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .jump_flag (jump_flag),
    .jump_pc   (jump_pc),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model + scoreboard state
  iq_entry_t   sb[$];
  logic [31:0] req_log[$];
  int          lat = 3;
  int          cnt = 0;
  int          npop = 0;
  bit          discard = 0;
  bit          req_prev = 0;
  bit          nd = 0;
  bit          chk_on = 0;
  iq_entry_t   ent;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Memory controller: answers mc_req after lat sampled cycles; scoreboard
  // tracks which responses the fetcher must keep.
  initial begin
    bus.mc_done = 1'b0;
    bus.mc_data = 32'h0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        sb.delete();
        discard = 0;
        cnt = 0;
        nd = 0;
      end else if (rdy) begin
        if (jump_flag) begin
          sb.delete();
          discard = bus.mc_req && !bus.mc_done;
        end else if (bus.mc_done) begin
          if (discard) discard = 0;
          else begin
            ent.pc = bus.mc_addr;
            ent.inst = bus.mc_data;
            sb.push_back(ent);
          end
        end
        if (bus.mc_done) begin
          nd = 0;
          cnt = 0;
        end else if (bus.mc_req) begin
          cnt++;
          nd = (cnt >= lat);
        end else nd = 0;
      end
      if (rst_n && bus.mc_req && !req_prev) req_log.push_back(bus.mc_addr);
      req_prev = bus.mc_req;
      #1;
      bus.mc_done = nd;
      bus.mc_data = nd ? word_of(bus.mc_addr) : 32'h0;
    end
  end

  // Dispatcher-side check against the scoreboard head, popping on accept.
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("inst_flag", {31'b0, bus.inst_flag}, {31'b0, sb.size() != 0});
      if (sb.size() != 0) begin
        chk("inst", bus.inst, sb[0].inst);
        chk("inst_pc", bus.inst_pc, sb[0].pc);
        if (rdy && !bus.ID_stall && !jump_flag) begin
          void'(sb.pop_front());
          npop++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input logic [31:0] addr, input string tag);
    for (int i = 0; i < 80; i++) begin
      if (bus.mc_req && bus.mc_addr == addr) break;
      tick();
    end
    chk({tag, "_seen"}, {31'b0, bus.mc_req}, 32'd1);
    chk(tag, bus.mc_addr, addr);
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 80; i++) begin
      if (req_log.size() >= n) break;
      tick();
    end
    chk("req_log_len", {31'b0, req_log.size() >= n}, 32'd1);
  endtask

  logic [31:0] s_addr, s_inst, s_pc;
  logic        s_req, s_flag;
  int          npop0;

  initial begin
    bus.ID_stall = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_on = 1;
    chk("rst_mc_req", {31'b0, bus.mc_req}, 32'd0);
    chk("rst_mc_addr", bus.mc_addr, 32'h0);
    chk("rst_inst_flag", {31'b0, bus.inst_flag}, 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    req_log.delete();

    // Fill with dispatcher stalled: exactly IQ_DEPTH fetches, then silence
    rst_n = 1'b1;
    repeat (40) tick();
    chk("stall_nreq", req_log.size(), 32'd4);
    chk("full_no_req", {31'b0, bus.mc_req}, 32'd0);
    for (int i = 0; i < 4; i++) chk("fill_addr", req_log[i], 32'(i * 4));
    bus.ID_stall = 1'b0;
    wait_log(5);
    chk("resume_addr", req_log[4], 32'h10);
    repeat (20) tick();

    // Redirect while waiting on 0x8: response dropped, DISCARD keeps request
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lat = 6;
    wait_req(32'h8, "wait_8");
    jump_pc = 32'h100;
    jump_flag = 1'b1;
    tick();
    jump_flag = 1'b0;
    chk("disc_req", {31'b0, bus.mc_req}, 32'd1);
    chk("disc_addr", bus.mc_addr, 32'h8);
    chk("flush_flag", {31'b0, bus.inst_flag}, 32'd0);
    wait_req(32'h100, "jump_target");
    for (int i = 0; i < 40; i++) begin
      if (bus.inst_flag) break;
      tick();
    end
    chk("jump_first_pc", bus.inst_pc, 32'h100);

    // Redirect coincident with mc_done
    lat = 3;
    for (int i = 0; i < 40; i++) begin
      if (bus.mc_done) break;
      tick();
    end
    chk("done_seen", {31'b0, bus.mc_done}, 32'd1);
    jump_pc = 32'h200;
    jump_flag = 1'b1;
    tick();
    jump_flag = 1'b0;
    chk("jd_req_idle", {31'b0, bus.mc_req}, 32'd0);
    chk("jd_flag", {31'b0, bus.inst_flag}, 32'd0);
    tick();
    chk("jd_req", {31'b0, bus.mc_req}, 32'd1);
    chk("jd_addr", bus.mc_addr, 32'h200);

    // Random stall: simultaneous push/pop at various fill levels, wrap
    lat = 1;
    npop0 = npop;
    for (int i = 0; i < 300; i++) begin
      bus.ID_stall = (i < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      tick();
    end
    bus.ID_stall = 1'b0;
    repeat (20) tick();
    chk("pops_min", {31'b0, (npop - npop0) >= 10}, 32'd1);

    // rdy low mid-WAIT freezes every output
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      if (bus.mc_req && !bus.mc_done) break;
      tick();
    end
    s_req = bus.mc_req;   s_addr = bus.mc_addr; s_flag = bus.inst_flag;
    s_inst = bus.inst;    s_pc = bus.inst_pc;
    chk("frz_in_wait", {31'b0, s_req}, 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_req", {31'b0, bus.mc_req}, {31'b0, s_req});
      chk("frz_addr", bus.mc_addr, s_addr);
      chk("frz_flag", {31'b0, bus.inst_flag}, {31'b0, s_flag});
      chk("frz_inst", bus.inst, s_inst);
      chk("frz_pc", bus.inst_pc, s_pc);
    end
    rdy = 1'b1;
    tick();

    // Reset mid-WAIT
    for (int i = 0; i < 20; i++) begin
      if (bus.mc_req) break;
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("mrst_req", {31'b0, bus.mc_req}, 32'd0);
    chk("mrst_flag", {31'b0, bus.inst_flag}, 32'd0);
    chk("mrst_addr", bus.mc_addr, 32'h0);
    req_log.delete();
    rst_n = 1'b1;
    wait_log(1);
    chk("mrst_pc", req_log[0], 32'h0);
    repeat (10) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
